mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction cache (ic) and data cache (dc).
//  Grants one line transaction at a time: a read refill or a dirty writeback.
//  Forwards that requester's request and write-data beats, then steers response beats back to the owner.
//  Sits between the two cache instances and the memory model / DRAM controller.
// PARAMETERS
//  ADDR_BITS   `CPU_ADDR_BITS-`ceilLog2(`MEM_DATA_BITS/8)  memory beat address width
//  DATA_BITS   `MEM_DATA_BITS (128)                       memory beat width
//  BEATS       4                                          beats per line (read resp and write data)
// PORTS
//  clk                  in   1            clock
//  reset                in   1            sync reset, active-high
//  {ic,dc}_req_val      in   1            requester line request valid
//  {ic,dc}_req_rdy      out  1            request accepted this cycle
//  {ic,dc}_req_addr     in   ADDR_BITS    line base beat address
//  {ic,dc}_req_rw       in   1            1=write(back), 0=read (ic_req_rw ignored, treated 0)
//  dc_req_data_valid    in   1            writeback beat valid
//  dc_req_data_ready    out  1            writeback beat accepted
//  dc_req_data_bits     in   DATA_BITS    writeback beat
//  dc_req_data_mask     in   DATA_BITS/8  byte mask
//  {ic,dc}_resp_val     out  1            response beat valid for that requester
//  resp_data            out  DATA_BITS    response beat, broadcast to both caches
//  mem_req_val/_rdy     out/in 1          memory request handshake
//  mem_req_addr         out  ADDR_BITS    granted address
//  mem_req_rw           out  1            granted rw
//  mem_req_data_valid/_ready out/in 1     write-data handshake
//  mem_req_data_bits    out  DATA_BITS    write beat
//  mem_req_data_mask    out  DATA_BITS/8  write mask
//  mem_resp_val         in   1            memory response beat valid
//  mem_resp_data        in   DATA_BITS    memory response beat
// BEHAVIOUR
//  Reset: state=IDLE, owner=DC, beat_cnt=0; all *_rdy, *_val, data_ready outputs 0.
//  FSM: IDLE -> REQ on any req_val; latch winner into owner, same cycle.
//   REQ: mem_req_val=1, addr/rw from owner; on mem_req_rdy: owner req_rdy pulses 1 (same cycle),
//   -> WDATA if rw else RRESP; beat_cnt=0.
//   WDATA: mem_req_data_valid=dc_req_data_valid, dc_req_data_ready=mem_req_data_ready;
//   each fire increments beat_cnt; fire with beat_cnt==BEATS-1 -> IDLE.
//   RRESP: owner resp_val=mem_resp_val, resp_data=mem_resp_data (combinational, 0-cycle latency);
//   mem_resp_val with beat_cnt==BEATS-1 -> IDLE.
//  Grant is held for the whole transaction; no preemption; non-owner rdy/resp_val stay 0.
//  Memory response beats are never back-pressured; the owner must accept every beat.
//  Without RR: dc has fixed priority when both are valid in IDLE.
//  Request fields are sampled from the owner each cycle in REQ; requesters hold them stable until rdy.
//  Min turnaround: IDLE cycle between transactions (1 cycle), so back-to-back grants are 1 cycle apart.
//  Reset mid-transaction: abandon immediately; no further beats are forwarded; memory side is reset by the same signal.
//  mem_resp_val outside RRESP: ignored (no resp_val asserted).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; when both are valid in IDLE, grant the one not served last
//   (last_grant register, reset to IC so dc wins the first tie).
//  Undefined: fixed dc-over-ic priority; last_grant register is absent.
// STRUCTURE
//  Shared package/header: state encoding (IDLE, REQ, WDATA, RRESP), owner encoding (OWN_IC, OWN_DC).
//  Single module; beat counter is ceilLog2(BEATS) bits and is inline, with no sub-module.
// TESTING
//  Single ic read, addr 0x10: mem_req_addr=0x10, rw=0; 4 mem_resp beats D0..D3 -> ic_resp_val x4, dc_resp_val=0.
//  dc writeback, addr 0x20, mem_req_data_ready toggling every cycle: exactly 4 beats pass, in order; returns to IDLE after beat 3.
//  ic and dc valid same cycle (no RR): dc granted first; ic granted right after dc's last beat + IDLE cycle.
//  RR enabled, both valid continuously: grants alternate dc, ic, dc, ic.
//  mem_req_rdy held 0 for 10 cycles: mem_req_val stays 1, addr stable, requester rdy 0; grant unchanged.
//  reset asserted after response beat 2 of a read: next cycle all outputs 0, state IDLE; a new request then completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings and default sizes for the memory arbiter.
// Revision: 1.0
`default_nettype none

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RRESP = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_e;

   localparam int unsigned MEM_DATA_BITS_DFLT = 128;
   localparam int unsigned ADDR_BITS_DFLT     = 28;
   localparam int unsigned BEATS_DFLT         = 4;

   // Keeps the beat counter at least one bit wide even for single-beat lines.
   function automatic int unsigned cnt_width(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared memory port to ic or dc one line transaction at a time.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed dc priority. Revision: 1.0
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_BITS = ADDR_BITS_DFLT,
   parameter int unsigned DATA_BITS = MEM_DATA_BITS_DFLT,
   parameter int unsigned BEATS     = BEATS_DFLT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ic_req_val,
   output logic                   ic_req_rdy,
   input  logic [ADDR_BITS-1:0]   ic_req_addr,
   input  logic                   ic_req_rw,
   input  logic                   dc_req_val,
   output logic                   dc_req_rdy,
   input  logic [ADDR_BITS-1:0]   dc_req_addr,
   input  logic                   dc_req_rw,
   input  logic                   dc_req_data_valid,
   output logic                   dc_req_data_ready,
   input  logic [DATA_BITS-1:0]   dc_req_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
   output logic                   ic_resp_val,
   output logic                   dc_resp_val,
   output logic [DATA_BITS-1:0]   resp_data,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_val,
   input  logic [DATA_BITS-1:0]   mem_resp_data
);

   localparam int unsigned CNT_W = cnt_width(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   owner_e           winner;
   logic             own_rw;
   logic             cnt_last;

`ifdef MEM_ARB_RR_EN
   owner_e last_grant_q, last_grant_d;

   always_comb begin
      if (ic_req_val && dc_req_val) begin
         winner = (last_grant_q == OWN_DC) ? OWN_IC : OWN_DC;
      end else begin
         winner = dc_req_val ? OWN_DC : OWN_IC;
      end
   end
`else
   always_comb begin
      winner = dc_req_val ? OWN_DC : OWN_IC;
   end
`endif

   // The icache never writes, so its rw input is deliberately ignored.
   assign own_rw   = (owner_q == OWN_DC) && dc_req_rw;
   assign cnt_last = (cnt_q == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_DC;
         cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= OWN_IC;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   always_comb begin
      state_d            = state_q;
      owner_d            = owner_q;
      cnt_d              = cnt_q;
`ifdef MEM_ARB_RR_EN
      last_grant_d       = last_grant_q;
`endif
      ic_req_rdy         = 1'b0;
      dc_req_rdy         = 1'b0;
      dc_req_data_ready  = 1'b0;
      ic_resp_val        = 1'b0;
      dc_resp_val        = 1'b0;
      mem_req_val        = 1'b0;
      mem_req_data_valid = 1'b0;
      mem_req_addr       = (owner_q == OWN_DC) ? dc_req_addr : ic_req_addr;
      mem_req_rw         = own_rw;
      mem_req_data_bits  = dc_req_data_bits;
      mem_req_data_mask  = dc_req_data_mask;
      resp_data          = mem_resp_data;

      case (state_q)
         ST_IDLE: begin
            if (ic_req_val || dc_req_val) begin
               state_d = ST_REQ;
               owner_d = winner;
`ifdef MEM_ARB_RR_EN
               last_grant_d = winner;
`endif
            end
         end
         ST_REQ: begin
            mem_req_val = 1'b1;
            if (mem_req_rdy) begin
               ic_req_rdy = (owner_q == OWN_IC);
               dc_req_rdy = (owner_q == OWN_DC);
               cnt_d      = '0;
               state_d    = own_rw ? ST_WDATA : ST_RRESP;
            end
         end
         ST_WDATA: begin
            mem_req_data_valid = dc_req_data_valid;
            dc_req_data_ready  = mem_req_data_ready;
            if (dc_req_data_valid && mem_req_data_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RRESP: begin
            ic_resp_val = mem_resp_val && (owner_q == OWN_IC);
            dc_resp_val = mem_resp_val && (owner_q == OWN_DC);
            if (mem_resp_val) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for stall, reset-abort and round-robin.
// Revision: 1.0
`default_nettype none

module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req_val, ic_req_rdy, ic_req_rw;
   logic [AW-1:0] ic_req_addr;
   logic          dc_req_val, dc_req_rdy, dc_req_rw;
   logic [AW-1:0] dc_req_addr;
   logic          dc_req_data_valid, dc_req_data_ready;
   logic [DW-1:0] dc_req_data_bits;
   logic [MW-1:0] dc_req_data_mask;
   logic          ic_resp_val, dc_resp_val;
   logic [DW-1:0] resp_data;
   logic          mem_req_val, mem_req_rdy, mem_req_rw;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_data_valid, mem_req_data_ready;
   logic [DW-1:0] mem_req_data_bits;
   logic [MW-1:0] mem_req_data_mask;
   logic          mem_resp_val;
   logic [DW-1:0] mem_resp_data;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
      .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
      .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
      .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
      .ic_resp_val(ic_resp_val), .dc_resp_val(dc_resp_val), .resp_data(resp_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
      .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
      .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   // in: {ic_val, dc_val, dc_rw, mem_rdy, dc_dvalid, mem_dready, mem_rval}
   // ex: {ic_rdy, dc_rdy, mem_val, mem_rw, mem_dvalid, dc_dready, ic_resp, dc_resp}
   typedef struct {
      logic [6:0]    in;
      logic [7:0]    ex;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [6:0] in, input logic [7:0] ex, input logic [AW-1:0] addr);
      vec_t v;
      v.in = in; v.ex = ex; v.addr = addr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {ic_req_rdy, dc_req_rdy, mem_req_val, mem_req_rw & mem_req_val,
              mem_req_data_valid, dc_req_data_ready, ic_resp_val, dc_resp_val};
   endfunction

   task automatic quiet();
      ic_req_val = 0; dc_req_val = 0; dc_req_rw = 0; mem_req_rdy = 0;
      dc_req_data_valid = 0; mem_req_data_ready = 0; mem_resp_val = 0;
   endtask

   // Delivers one response beat in the current cycle and checks it reaches the owner.
   task automatic beat(input string nm, input logic to_dc, input logic [DW-1:0] d);
      @(negedge clk);
      mem_resp_val = 1; mem_resp_data = d;
      #1;
      chk({nm, ".resp_val"}, {ic_resp_val, dc_resp_val}, to_dc ? 2'b01 : 2'b10);
      chk({nm, ".resp_data"}, resp_data, d);
   endtask

`ifdef MEM_ARB_RR_EN
   // Waits (bounded) for a grant, then supplies 4 read beats; returns which side got it.
   task automatic serve(output logic got_dc);
      bit done = 0;
      got_dc = 0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         mem_req_rdy = 1; mem_resp_val = 0;
         #1;
         if (ic_req_rdy || dc_req_rdy) begin
            done = 1; got_dc = dc_req_rdy;
         end
      end
      if (!done) chk("rr.grant_timeout", 0, 1);
      mem_req_rdy = 0;
      for (int b = 0; b < 4; b++) beat("rr.beat", got_dc, DW'(b));
      @(negedge clk);
      mem_resp_val = 0;
   endtask
`endif

   initial begin
      ic_req_addr = AW'('h10); dc_req_addr = AW'('h20);
      ic_req_rw = 1;  // must be ignored
      dc_req_data_bits = '0; dc_req_data_mask = '1; mem_resp_data = '0;
      quiet();
      reset = 1;
      mem_req_rdy = 1; mem_resp_val = 1; ic_req_val = 1; dc_req_val = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset.outs", outs(), 8'h00);
      quiet();
      reset = 0;

`ifndef MEM_ARB_RR_EN
      // ic read of 0x10, with one stall cycle and a gap between beats
      add(7'b1000000, 8'b00000000, 0);
      add(7'b1000000, 8'b00100000, AW'('h10));
      add(7'b1001000, 8'b10100000, AW'('h10));
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000000, 8'b00000000, 0);
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000010, 0);
      // dc writeback to 0x20 with mem_req_data_ready toggling; stray resp ignored in IDLE
      add(7'b0110001, 8'b00000000, 0);
      add(7'b0111000, 8'b01110000, AW'('h20));
      add(7'b0010100, 8'b00001000, 0);
      add(7'b0010110, 8'b00001100, 0);
      add(7'b0010010, 8'b00000100, 0);
      add(7'b0010100, 8'b00001000, 0);
      add(7'b0010110, 8'b00001100, 0);
      add(7'b0010100, 8'b00001000, 0);
      add(7'b0010110, 8'b00001100, 0);
      add(7'b0010100, 8'b00001000, 0);
      add(7'b0010110, 8'b00001100, 0);
      add(7'b0010110, 8'b00000000, 0);
      // tie: dc read wins, ic follows after dc's last beat plus an IDLE cycle
      add(7'b1100000, 8'b00000000, 0);
      add(7'b1101000, 8'b01100000, AW'('h20));
      add(7'b1000001, 8'b00000001, 0);
      add(7'b1000001, 8'b00000001, 0);
      add(7'b1000001, 8'b00000001, 0);
      add(7'b1000001, 8'b00000001, 0);
      add(7'b1000000, 8'b00000000, 0);
      add(7'b1001000, 8'b10100000, AW'('h10));
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000010, 0);
      add(7'b0000001, 8'b00000000, 0);

      foreach (vecs[k]) begin
         @(negedge clk);
         {ic_req_val, dc_req_val, dc_req_rw, mem_req_rdy,
          dc_req_data_valid, mem_req_data_ready, mem_resp_val} = vecs[k].in;
         dc_req_data_bits = DW'(k) + DW'('hBEEF0000);
         #1;
         chk($sformatf("vec%0d.outs", k), outs(), vecs[k].ex);
         if (vecs[k].ex[5]) chk($sformatf("vec%0d.addr", k), mem_req_addr, vecs[k].addr);
         if (vecs[k].ex[3]) chk($sformatf("vec%0d.wbits", k), mem_req_data_bits, dc_req_data_bits);
      end
`else
      begin
         logic g0, g1, g2, g3;
         ic_req_val = 1; dc_req_val = 1;
         serve(g0); serve(g1); serve(g2); serve(g3);
         chk("rr.order", {g0, g1, g2, g3}, 4'b1010);
         quiet();
      end
`endif

      // Stall: mem_req_rdy low for 10 cycles while dc also requests
      @(negedge clk); quiet(); ic_req_val = 1;
      @(negedge clk); dc_req_val = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("stall%0d.val_rdy", c), {mem_req_val, ic_req_rdy, dc_req_rdy}, 3'b100);
         chk($sformatf("stall%0d.addr", c), mem_req_addr, AW'('h10));
         @(negedge clk);
      end
      mem_req_rdy = 1;
      #1;
      chk("stall.grant", {ic_req_rdy, dc_req_rdy, mem_req_rw}, 3'b100);
      @(negedge clk); quiet();
      for (int b = 0; b < 4; b++) beat($sformatf("stall.beat%0d", b), 1'b0, DW'('hD0 + b));

      // Reset mid-read after three beats, then a fresh dc read
      @(negedge clk); quiet(); ic_req_val = 1;
      @(negedge clk); mem_req_rdy = 1;
      @(negedge clk); quiet();
      for (int b = 0; b < 3; b++) beat($sformatf("abort.beat%0d", b), 1'b0, DW'('hA0 + b));
      @(negedge clk);
      reset = 1; mem_resp_val = 0;
      @(negedge clk);
      reset = 0; mem_resp_val = 1; mem_req_rdy = 1; mem_req_data_ready = 1;
      #1;
      chk("abort.outs", outs(), 8'h00);
      @(negedge clk); quiet(); dc_req_val = 1;
      #1;
      chk("after.idle", outs(), 8'h00);
      @(negedge clk); mem_req_rdy = 1;
      #1;
      chk("after.grant", outs(), 8'b01100000);
      chk("after.addr", mem_req_addr, AW'('h20));
      @(negedge clk); quiet();
      for (int b = 0; b < 4; b++) beat($sformatf("after.beat%0d", b), 1'b1, {4{32'hC0DE_0000 + b}});
      @(negedge clk); quiet(); mem_resp_val = 1;
      #1;
      chk("after.done", outs(), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
